// File: rtl/exception_sequencer.sv
// exception_sequencer
// -------------------
// Multi-cycle controller that sits beside control_unit. It turns EX/MEM-stage
// exception events into an ordered sequence:
//   1. freeze the pipeline,
//   2. commit CP0 state and flush the pipeline,
//   3. redirect the PC.
// The events are syscall, reserved instruction, external interrupt and eret.
//
// Optional build macro:
//   INTR_SYNC_EN - when defined, cp0_intr passes through a 2-flop
//                  synchronizer (reset to 0) before the event logic sees it.
//                  This adds 2 cycles of interrupt latency.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   mem_stall             memory stage busy (pipeline already frozen)
//   exmem_syscall/ri/eret exception sources sitting in EX/MEM
//   cp0_intr              pending and enabled interrupt (level)
//   cp0_status_exl        CP0 Status.EXL; masks interrupts when set
//   cp0_epc_q             current CP0 EPC, the eret target
//   exmem_pc, exmem_bd    PC and delay-slot flag of the EX/MEM instruction
//   cu_exc_stall          freezes PC/IFID/IDEX/EXMEM
//   cu_*_flush            one-cycle flush of the stage registers
//   cu_cp0_w_en           writes EPC, Cause.ExcCode and Cause.BD
//   cu_exec_code          value written to Cause.ExcCode
//   cu_epc                value written to EPC
//   cu_bd                 value written to Cause.BD
//   cu_set_exl/cu_clr_exl strobes that set or clear EXL
//   cu_pc_redirect        PC loads cu_vector on the next edge
//   cu_vector             redirect target
//   busy                  high whenever the sequencer is not idle
module exception_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter logic [4:0]  CODE_INT   = 5'd0,
    parameter logic [4:0]  CODE_SYS   = 5'd8,
    parameter logic [4:0]  CODE_RI    = 5'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_stall,
    input  logic        exmem_syscall,
    input  logic        exmem_ri,
    input  logic        exmem_eret,
    input  logic        cp0_intr,
    input  logic        cp0_status_exl,
    input  logic [31:0] cp0_epc_q,
    input  logic [31:0] exmem_pc,
    input  logic        exmem_bd,
    output logic        cu_exc_stall,
    output logic        cu_ifid_flush,
    output logic        cu_idex_flush,
    output logic        cu_exmem_flush,
    output logic        cu_cp0_w_en,
    output logic [4:0]  cu_exec_code,
    output logic [31:0] cu_epc,
    output logic        cu_bd,
    output logic        cu_set_exl,
    output logic        cu_clr_exl,
    output logic        cu_pc_redirect,
    output logic [31:0] cu_vector,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        intr_eff;
    logic        ev;
    logic        capture;

    logic        win_eret;
    logic [4:0]  win_code;
    logic [31:0] win_epc;
    logic        win_bd;
    logic [31:0] win_vector;
    logic [31:0] restart_pc;

    logic        cap_eret;
    logic [4:0]  cap_code;
    logic [31:0] cap_epc;
    logic        cap_bd;
    logic [31:0] cap_vector;

`ifdef INTR_SYNC_EN
    // cp0_intr may come from an asynchronous source, so it is retimed
    // through two flops before the event logic uses it.
    logic intr_meta;
    logic intr_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            intr_meta <= 1'b0;
            intr_sync <= 1'b0;
        end else begin
            intr_meta <= cp0_intr;
            intr_sync <= intr_meta;
        end
    end

    assign intr_eff = intr_sync;
`else
    assign intr_eff = cp0_intr;
`endif

    // An interrupt only counts while EXL is clear. This also stops a held
    // interrupt from retriggering once the handler has been entered.
    assign ev = exmem_syscall | exmem_ri | (intr_eff & ~cp0_status_exl) | exmem_eret;

    // Faulting instructions in a delay slot restart at the branch. The
    // subtraction wraps modulo 2^32.
    assign restart_pc = exmem_bd ? (exmem_pc - 32'd4) : exmem_pc;

    // Resolve the fixed priority syscall > ri > interrupt > eret. Only the
    // winner's fields are captured. For eret there is no EPC/Cause write,
    // so its code, EPC and BD stay zero.
    always_comb begin
        win_eret   = 1'b0;
        win_code   = 5'd0;
        win_epc    = 32'd0;
        win_bd     = 1'b0;
        win_vector = EXC_VECTOR;
        if (exmem_syscall) begin
            win_code = CODE_SYS;
            win_epc  = restart_pc;
            win_bd   = exmem_bd;
        end else if (exmem_ri) begin
            win_code = CODE_RI;
            win_epc  = restart_pc;
            win_bd   = exmem_bd;
        end else if (intr_eff & ~cp0_status_exl) begin
            win_code = CODE_INT;
            win_epc  = restart_pc;
            win_bd   = exmem_bd;
        end else begin
            win_eret   = 1'b1;
            win_vector = cp0_epc_q;
        end
    end

    assign capture = (state == IDLE) && ev && !mem_stall;

    // State register plus the captured exception record. The record is
    // loaded only on the accepting IDLE cycle, so it stays stable for the
    // rest of the sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cap_eret   <= 1'b0;
            cap_code   <= 5'd0;
            cap_epc    <= 32'd0;
            cap_bd     <= 1'b0;
            cap_vector <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                cap_eret   <= win_eret;
                cap_code   <= win_code;
                cap_epc    <= win_epc;
                cap_bd     <= win_bd;
                cap_vector <= win_vector;
            end
        end
    end

    // Next state and strobes. COMMIT waits out mem_stall with every strobe
    // low, so the CP0 write and the flushes happen exactly once.
    always_comb begin
        state_next     = state;
        cu_exc_stall   = 1'b0;
        cu_ifid_flush  = 1'b0;
        cu_idex_flush  = 1'b0;
        cu_exmem_flush = 1'b0;
        cu_cp0_w_en    = 1'b0;
        cu_set_exl     = 1'b0;
        cu_clr_exl     = 1'b0;
        cu_pc_redirect = 1'b0;
        cu_vector      = 32'd0;
        case (state)
            IDLE: begin
                if (ev && !mem_stall) begin
                    cu_exc_stall = 1'b1;
                    state_next   = COMMIT;
                end
            end
            COMMIT: begin
                cu_exc_stall = 1'b1;
                if (!mem_stall) begin
                    cu_ifid_flush  = 1'b1;
                    cu_idex_flush  = 1'b1;
                    cu_exmem_flush = 1'b1;
                    if (cap_eret) begin
                        cu_clr_exl = 1'b1;
                    end else begin
                        cu_cp0_w_en = 1'b1;
                        cu_set_exl  = 1'b1;
                    end
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                cu_pc_redirect = 1'b1;
                cu_vector      = cap_vector;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // The captured fields are visible only while a sequence is in flight.
    // In IDLE they read as zero.
    assign cu_exec_code = busy ? cap_code : 5'd0;
    assign cu_epc       = busy ? cap_epc  : 32'd0;
    assign cu_bd        = busy ? cap_bd   : 1'b0;

endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer
// ----------------------
// Self-checking bench for exception_sequencer in its default build, where
// cp0_intr is used directly. It runs directed scenarios first, then
// randomized transactions. Both are compared against a behavioural
// prediction of each exception's outcome.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_stall;
    logic        exmem_syscall;
    logic        exmem_ri;
    logic        exmem_eret;
    logic        cp0_intr;
    logic        cp0_status_exl;
    logic [31:0] cp0_epc_q;
    logic [31:0] exmem_pc;
    logic        exmem_bd;
    logic        cu_exc_stall;
    logic        cu_ifid_flush;
    logic        cu_idex_flush;
    logic        cu_exmem_flush;
    logic        cu_cp0_w_en;
    logic [4:0]  cu_exec_code;
    logic [31:0] cu_epc;
    logic        cu_bd;
    logic        cu_set_exl;
    logic        cu_clr_exl;
    logic        cu_pc_redirect;
    logic [31:0] cu_vector;
    logic        busy;

    int assert_count = 0;
    int fail_count   = 0;

    exception_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .mem_stall      (mem_stall),
        .exmem_syscall  (exmem_syscall),
        .exmem_ri       (exmem_ri),
        .exmem_eret     (exmem_eret),
        .cp0_intr       (cp0_intr),
        .cp0_status_exl (cp0_status_exl),
        .cp0_epc_q      (cp0_epc_q),
        .exmem_pc       (exmem_pc),
        .exmem_bd       (exmem_bd),
        .cu_exc_stall   (cu_exc_stall),
        .cu_ifid_flush  (cu_ifid_flush),
        .cu_idex_flush  (cu_idex_flush),
        .cu_exmem_flush (cu_exmem_flush),
        .cu_cp0_w_en    (cu_cp0_w_en),
        .cu_exec_code   (cu_exec_code),
        .cu_epc         (cu_epc),
        .cu_bd          (cu_bd),
        .cu_set_exl     (cu_set_exl),
        .cu_clr_exl     (cu_clr_exl),
        .cu_pc_redirect (cu_pc_redirect),
        .cu_vector      (cu_vector),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic sys, input logic ri, input logic eret,
                                  input logic intr, input logic exl, input logic stall,
                                  input logic [31:0] pc, input logic bd, input logic [31:0] epcq);
        exmem_syscall  = sys;
        exmem_ri       = ri;
        exmem_eret     = eret;
        cp0_intr       = intr;
        cp0_status_exl = exl;
        mem_stall      = stall;
        exmem_pc       = pc;
        exmem_bd       = bd;
        cp0_epc_q      = epcq;
    endtask

    task automatic check_strobes(input string tag, input logic e_stall, input logic e_flush,
                                 input logic e_wen, input logic e_set, input logic e_clr,
                                 input logic e_redir, input logic e_busy);
        check_output({tag, ".exc_stall"}, {31'd0, cu_exc_stall}, {31'd0, e_stall});
        check_output({tag, ".flushes"}, {29'd0, cu_ifid_flush, cu_idex_flush, cu_exmem_flush},
                     {29'd0, e_flush, e_flush, e_flush});
        check_output({tag, ".cp0_w_en"}, {31'd0, cu_cp0_w_en}, {31'd0, e_wen});
        check_output({tag, ".set_exl"}, {31'd0, cu_set_exl}, {31'd0, e_set});
        check_output({tag, ".clr_exl"}, {31'd0, cu_clr_exl}, {31'd0, e_clr});
        check_output({tag, ".pc_redirect"}, {31'd0, cu_pc_redirect}, {31'd0, e_redir});
        check_output({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    endtask

    task automatic check_all_zero(input string tag);
        check_strobes(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output({tag, ".exec_code"}, {27'd0, cu_exec_code}, 32'd0);
        check_output({tag, ".epc"}, cu_epc, 32'd0);
        check_output({tag, ".bd"}, {31'd0, cu_bd}, 32'd0);
        check_output({tag, ".vector"}, cu_vector, 32'd0);
    endtask

    // Behavioural prediction: which event wins, and what the CP0 write and
    // redirect target should be.
    function automatic void predict(input logic sys, input logic ri, input logic eret,
                                    input logic intr, input logic exl,
                                    input logic [31:0] pc, input logic bd, input logic [31:0] epcq,
                                    output logic ev, output logic is_eret, output logic [4:0] code,
                                    output logic [31:0] epc, output logic e_bd,
                                    output logic [31:0] vec);
        logic [31:0] restart;
        restart = bd ? pc - 32'd4 : pc;
        ev      = 1'b1;
        is_eret = 1'b0;
        code    = 5'd0;
        epc     = restart;
        e_bd    = bd;
        vec     = 32'h0000_0180;
        if (sys)              code = 5'd8;
        else if (ri)          code = 5'd10;
        else if (intr && !exl) code = 5'd0;
        else if (eret) begin
            is_eret = 1'b1;
            vec     = epcq;
        end else ev = 1'b0;
    endfunction

    task automatic check_fields(input string tag, input logic is_eret, input logic [4:0] code,
                                input logic [31:0] epc, input logic e_bd);
        if (!is_eret) begin
            check_output({tag, ".exec_code"}, {27'd0, cu_exec_code}, {27'd0, code});
            check_output({tag, ".epc"}, cu_epc, epc);
            check_output({tag, ".bd"}, {31'd0, cu_bd}, {31'd0, e_bd});
        end
    endtask

    // One complete transaction from the event cycle T back to IDLE. The
    // commit_stalls argument sets how many COMMIT cycles have mem_stall
    // high. When noise is set, the event inputs stay asserted while the
    // sequencer is busy, and those events must be ignored.
    task automatic run_txn(input string tag, input logic sys, input logic ri, input logic eret,
                           input logic intr, input logic exl, input logic [31:0] pc,
                           input logic bd, input logic [31:0] epcq,
                           input int commit_stalls, input logic noise);
        logic ev, is_eret, e_bd;
        logic [4:0] code;
        logic [31:0] epc, vec;
        logic n_sys, n_ri, n_eret, n_intr;
        predict(sys, ri, eret, intr, exl, pc, bd, epcq, ev, is_eret, code, epc, e_bd, vec);
        n_sys  = noise & sys;
        n_ri   = noise & ri;
        n_eret = noise & eret;
        n_intr = noise & intr;

        @(negedge clk);
        apply_stimulus(sys, ri, eret, intr, exl, 1'b0, pc, bd, epcq);
        #1;
        if (!ev) begin
            check_strobes({tag, ".noev"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            #1;
            check_output({tag, ".noev_busy"}, {31'd0, busy}, 32'd0);
            return;
        end
        check_strobes({tag, ".T"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < commit_stalls; k++) begin
            @(negedge clk);
            apply_stimulus(n_sys, n_ri, n_eret, n_intr, exl, 1'b1, pc, bd, epcq);
            #1;
            check_strobes({tag, ".hold"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_fields({tag, ".hold"}, is_eret, code, epc, e_bd);
        end

        @(negedge clk);
        apply_stimulus(n_sys, n_ri, n_eret, n_intr, exl, 1'b0, pc, bd, epcq);
        #1;
        check_strobes({tag, ".commit"}, 1'b1, 1'b1, !is_eret, !is_eret, is_eret, 1'b0, 1'b1);
        check_fields({tag, ".commit"}, is_eret, code, epc, e_bd);

        @(negedge clk);
        apply_stimulus(n_sys, n_ri, n_eret, n_intr, exl, noise & $urandom_range(0, 1), pc, bd, epcq);
        #1;
        check_strobes({tag, ".redir"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output({tag, ".vector"}, cu_vector, vec);
        check_fields({tag, ".redir"}, is_eret, code, epc, e_bd);

        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        check_strobes({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("post_reset");

        // Syscall with the minimum-latency sequence.
        run_txn("syscall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 32'd0, 0, 1'b0);
        // Reserved instruction in a delay slot.
        run_txn("ri_bd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0024, 1'b1, 32'd0, 0, 1'b0);
        // eret returns to EPC.
        run_txn("eret", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0040_0014, 0, 1'b0);
        // A syscall beats a simultaneous interrupt.
        run_txn("prio", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0030, 1'b0, 32'd0, 0, 1'b0);
        // Interrupt alone.
        run_txn("intr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0040, 1'b0, 32'd0, 0, 1'b0);
        // Delay-slot PC wraps below zero.
        run_txn("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'd0, 0, 1'b0);
        // mem_stall during COMMIT for 2 cycles.
        run_txn("commit_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0050, 1'b0, 32'd0, 2, 1'b0);

        // A held interrupt is masked while EXL is set.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0060, 1'b0, 32'd0);
            #1;
            check_strobes("exl_mask", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // An event under mem_stall in IDLE is not captured.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0070, 1'b0, 32'd0);
            #1;
            check_strobes("idle_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_txn("after_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0070, 1'b0, 32'd0, 0, 1'b0);

        // Reset while in COMMIT aborts the sequence with no CP0 write.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0080, 1'b0, 32'd0);
        #1;
        check_output("rst_commit.T", {31'd0, cu_exc_stall}, 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0080, 1'b0, 32'd0);
        #1;
        check_strobes("rst_commit.hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        check_all_zero("rst_commit.after");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_strobes("rst_commit.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Randomized transactions.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            if (i % 8 == 0) pc = 32'd0;
            run_txn("rand",
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
Multi-cycle controller that turns EX/MEM-stage exception events (syscall, reserved instruction, external interrupt, eret) into an ordered sequence: freeze, CP0 commit plus pipeline flush, then PC redirect. It sits beside control_unit and owns the cu_cp0_w_en, cu_exec_code, cu_epc and vector outputs. control_unit ORs cu_exc_stall and the flushes into its own stall/flush outputs. It selects the PC source from cu_pc_redirect.

Parameters:
EXC_VECTOR, 32'h0000_0180, handler entry address driven on redirect for syscall/RI/interrupt.
CODE_INT, 5'd0, exec code for interrupt.
CODE_SYS, 5'd8, exec code for syscall.
CODE_RI, 5'd10, exec code for reserved instruction.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous reset, active-high.
mem_stall  in  1  memory stage busy; pipeline already frozen by control_unit.
exmem_syscall  in  1  syscall in EX/MEM.
exmem_ri  in  1  reserved instruction in EX/MEM.
exmem_eret  in  1  eret in EX/MEM.
cp0_intr  in  1  pending and enabled interrupt (level).
cp0_status_exl  in  1  CP0 Status.EXL.
cp0_epc_q  in  32  current CP0 EPC, eret target.
exmem_pc  in  32  PC of EX/MEM instruction.
exmem_bd  in  1  EX/MEM instruction is in a branch delay slot.
cu_exc_stall  out  1  freeze PC/IFID/IDEX/EXMEM.
cu_ifid_flush, cu_idex_flush, cu_exmem_flush  out  1 each  flush stage registers.
cu_cp0_w_en  out  1  write EPC/Cause.ExcCode/Cause.BD.
cu_exec_code  out  5  Cause.ExcCode value.
cu_epc  out  32  EPC value to write.
cu_bd  out  1  Cause.BD value.
cu_set_exl, cu_clr_exl  out  1 each  EXL set/clear strobes.
cu_pc_redirect  out  1  PC takes cu_vector next edge.
cu_vector  out  32  redirect target.
busy  out  1  state != IDLE.

Behaviour:
- Reset to IDLE. Clock is clk; reset is synchronous and active-high. All outputs are 0 in the cycle after reset is sampled high, including cu_vector, cu_epc and cu_exec_code. Reset mid-sequence aborts with no partial CP0 write afterwards.
- Event valid (ev) = syscall | ri | (cp0_intr & ~cp0_status_exl) | eret.
- Fixed priority: syscall > ri > intr > eret. Only the winner is captured.
- States: IDLE, COMMIT, REDIRECT.
- IDLE:
  - If ev & ~mem_stall: cu_exc_stall=1 combinationally in that same cycle. Capture the winner's kind, code and target; next state COMMIT.
  - If ev & mem_stall: nothing is captured and cu_exc_stall=0. Re-evaluate next cycle.
- Captured EPC:
  - syscall/RI: exmem_bd ? exmem_pc-4 : exmem_pc; cu_bd=exmem_bd.
  - Interrupt: the same rule applies. The EX/MEM instruction is flushed and re-executed.
  - eret: target = cp0_epc_q, no EPC write.
- COMMIT:
  - cu_exc_stall=1.
  - While mem_stall=1, hold state with strobes low.
  - When mem_stall=0, pulse for exactly one cycle: all three flushes and cu_exc_stall. For non-eret, also pulse cu_cp0_w_en and cu_set_exl. For eret, pulse cu_clr_exl instead. Then go to REDIRECT.
  - cu_exec_code, cu_epc and cu_bd are held stable from the cycle after capture until IDLE.
- REDIRECT:
  - cu_pc_redirect=1 for one cycle; cu_exc_stall=0.
  - cu_vector = EXC_VECTOR for non-eret, otherwise the captured EPC target. Then go to IDLE.
- Minimum latency from event sample (T) to PC redirect: COMMIT strobe at T+1, redirect at T+2, IDLE at T+3.
- Events arriving while busy are ignored. The flush removes their source, and a held interrupt is masked by EXL.
- Simultaneous syscall and interrupt: syscall is taken. The interrupt is re-sampled after eret clears EXL.
- PC arithmetic is 32-bit modulo. The wrap case exmem_pc=0 with bd gives 32'hFFFF_FFFC.

Optional Feature:
INTR_SYNC_EN: when defined, cp0_intr passes through a 2-flop synchronizer, reset to 0, before ev/priority logic. This adds 2 cycles of interrupt latency; syscall, RI and eret are unaffected. When undefined, cp0_intr is used directly in the same cycle.

Test Plan:
- Syscall: exmem_syscall=1, exmem_pc=32'h0040_0010, bd=0 -> T: exc_stall=1. T+1: cp0_w_en=1, exec_code=8, epc=32'h0040_0010, set_exl=1, all flushes=1. T+2: pc_redirect=1, vector=32'h180.
- Delay-slot RI: exmem_ri=1, pc=32'h0040_0024, bd=1 -> epc=32'h0040_0020, cu_bd=1, exec_code=10.
- Eret: exmem_eret=1, cp0_epc_q=32'h0040_0014 -> T+1: clr_exl=1, cp0_w_en=0. T+2: vector=32'h0040_0014.
- Priority and mask: syscall=1 and cp0_intr=1 together -> code 8. Then with EXL=1 and cp0_intr=1 held for 10 cycles -> busy stays 0.
- mem_stall: event with mem_stall=1 for 3 cycles -> no capture, exc_stall=0. mem_stall raised during COMMIT for 2 cycles -> w_en pulses once, after it falls.
- Reset in COMMIT: reset=1 for one cycle -> next cycle all outputs 0, busy=0, no cp0_w_en pulse afterwards.
